toggle_decoder: RTL and testbench

Receive-side counterpart of the team's toggle (T) latch encoders. Takes a toggle-encoded level driven from another clock domain or an upstream T-latch stage, synchronizes it, and converts each level change back into one event. Events are queued in a saturating counter and drained through a valid/ready handshake. Each consumed event is acknowledged to the sender with a toggle on ACK_T, which forms a two-phase handshake.

---
 rtl/toggle_pkg.sv | 17 +
 rtl/toggle_sync.sv | 24 ++
 rtl/toggle_decoder.sv | 140 ++++++++++++++
 tb/tb_toggle_decoder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/toggle_pkg.sv
// Shared types and limits for the toggle decoder family.
package toggle_pkg;

  // Decoder FSM: WARMUP masks detect while the synchronizer fills, RUN counts events.
  typedef enum logic {
    WARMUP = 1'b0,
    RUN    = 1'b1
  } state_t;

  // Legal synchronizer depth range.
  localparam int MIN_SYNC = 2;
  localparam int MAX_SYNC = 4;

  // Warmup counter width, wide enough to count MAX_SYNC+1 cycles.
  localparam int WARM_W = $clog2(MAX_SYNC + 1);

endpackage

// File: rtl/toggle_sync.sv
// N-flop level synchronizer with asynchronous reset to 0.
module toggle_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [N-1:0] sync_r;

  // Shift the asynchronous level through N flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= {N{1'b0}};
    end else begin
      sync_r <= {sync_r[N-2:0], d};
    end
  end

  assign q = sync_r[N-1];

endmodule

// File: rtl/toggle_decoder.sv
// Toggle-encoded event receiver: synchronize T_IN, turn each level change into
// one queued event, drain events over valid/ready and acknowledge each consumed
// event with a toggle on ACK_T.
module toggle_decoder
  import toggle_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4
) (
  input  logic             C,
  input  logic             RST,
  input  logic             T_IN,
  input  logic             EVT_READY,
  input  logic             CLR_OVF,
  output logic             EVT_VALID,
  output logic [CNT_W-1:0] EVT_COUNT,
  output logic             ACK_T,
  output logic             OVF
);

  // Depth clamped into the legal range so an illegal parameter still builds.
  localparam int SYNC_N = (SYNC_STAGES < MIN_SYNC) ? MIN_SYNC :
                          (SYNC_STAGES > MAX_SYNC) ? MAX_SYNC : SYNC_STAGES;
  // Last warmup count value: WARMUP lasts SYNC_N+1 cycles (0..SYNC_N).
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(SYNC_N);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t             state_r;
  state_t             state_nxt_s;
  logic [WARM_W-1:0]  warm_cnt_r;
  logic [WARM_W-1:0]  warm_nxt_s;
  logic               sync_out_s;
  logic               prev_r;
  logic               tgl_s;
  logic               consume_s;
  logic               ovf_set_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   cnt_nxt_s;
  logic               ack_r;
  logic               ack_nxt_s;
  logic               ovf_r;
  logic               ovf_nxt_s;

  toggle_sync #(.N(SYNC_N)) u_sync (
    .clk (C),
    .rst (RST),
    .d   (T_IN),
    .q   (sync_out_s)
  );

  // Level changes only count once the synchronizer contents are trustworthy.
  assign tgl_s     = (state_r == RUN) & (sync_out_s ^ prev_r);
  assign consume_s = EVT_VALID & EVT_READY;

  // FSM state and warmup counter registers.
  always_ff @(posedge C or posedge RST) begin
    if (RST) begin
      state_r    <= WARMUP;
      warm_cnt_r <= {WARM_W{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      warm_cnt_r <= warm_nxt_s;
    end
  end

  // Next-state: leave WARMUP after SYNC_N+1 cycles, then stay in RUN.
  always_comb begin
    state_nxt_s = state_r;
    warm_nxt_s  = warm_cnt_r;
    case (state_r)
      WARMUP: begin
        if (warm_cnt_r == WARM_LAST) begin
          state_nxt_s = RUN;
        end else begin
          warm_nxt_s = warm_cnt_r + {{(WARM_W-1){1'b0}}, 1'b1};
        end
      end
      RUN: begin
        state_nxt_s = RUN;
      end
      default: begin
        state_nxt_s = WARMUP;
        warm_nxt_s  = {WARM_W{1'b0}};
      end
    endcase
  end

  // Event counter, acknowledge toggle and sticky overflow next values.
  always_comb begin
    cnt_nxt_s = cnt_r;
    ovf_set_s = 1'b0;
    case ({tgl_s, consume_s})
      2'b10: begin
        if (cnt_r == CNT_MAX) begin
          ovf_set_s = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      2'b01: begin
        cnt_nxt_s = cnt_r - CNT_ONE;
      end
      // Idle, or arrival and consume cancel out (also covers arrival at full).
      default: begin
        cnt_nxt_s = cnt_r;
      end
    endcase
    ack_nxt_s = ack_r ^ consume_s;
    // A fresh overflow outranks a clear in the same cycle.
    if (ovf_set_s) begin
      ovf_nxt_s = 1'b1;
    end else if (CLR_OVF) begin
      ovf_nxt_s = 1'b0;
    end else begin
      ovf_nxt_s = ovf_r;
    end
  end

  // Datapath registers; prev tracks sync_out in every state.
  always_ff @(posedge C or posedge RST) begin
    if (RST) begin
      prev_r <= 1'b0;
      cnt_r  <= {CNT_W{1'b0}};
      ack_r  <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      prev_r <= sync_out_s;
      cnt_r  <= cnt_nxt_s;
      ack_r  <= ack_nxt_s;
      ovf_r  <= ovf_nxt_s;
    end
  end

  assign EVT_COUNT = cnt_r;
  assign EVT_VALID = (cnt_r != {CNT_W{1'b0}});
  assign ACK_T     = ack_r;
  assign OVF       = ovf_r;

endmodule

// File: tb/tb_toggle_decoder.sv
// Scoreboard bench for toggle_decoder with a cycle-level event model.
module tb_toggle_decoder;

  localparam int SS   = 2;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          C = 1'b0;
  logic          RST = 1'b1;
  logic          T_IN = 1'b0;
  logic          EVT_READY = 1'b0;
  logic          CLR_OVF = 1'b0;
  logic          EVT_VALID;
  logic [CW-1:0] EVT_COUNT;
  logic          ACK_T;
  logic          OVF;

  toggle_decoder #(.SYNC_STAGES(SS), .CNT_W(CW)) dut (
    .C         (C),
    .RST       (RST),
    .T_IN      (T_IN),
    .EVT_READY (EVT_READY),
    .CLR_OVF   (CLR_OVF),
    .EVT_VALID (EVT_VALID),
    .EVT_COUNT (EVT_COUNT),
    .ACK_T     (ACK_T),
    .OVF       (OVF)
  );

  always #5 C = ~C;

  typedef struct {
    int cnt;
    int valid;
    int ack;
    int ovf;
  } exp_t;

  exp_t exp_q[$];
  int   arr_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model state
  int k;
  int m_cnt;
  int m_ack;
  int m_ovf;
  logic t_last;

  // Handshake / ack observation
  int   n_hs;
  int   n_ack;
  logic ack_prev;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    k = 0; m_cnt = 0; m_ack = 0; m_ovf = 0; t_last = 1'b0;
    arr_q.delete();
  endtask

  // One clock edge: advance the model and post the expected outputs.
  task automatic step();
    bit ev;
    bit cons;
    bit ovf_new;
    exp_t e;
    @(posedge C);
    k++;
    ev = 1'b0;
    if (arr_q.size() > 0 && arr_q[0] == k) begin
      void'(arr_q.pop_front());
      ev = (k >= SS + 2);      // events arriving during warmup are discarded
    end
    cons    = (m_cnt > 0) && EVT_READY;
    ovf_new = 1'b0;
    if (ev && !cons) begin
      if (m_cnt == CMAX) ovf_new = 1'b1;
      else m_cnt++;
    end else if (cons && !ev) begin
      m_cnt--;
    end
    if (cons) m_ack = 1 - m_ack;
    if (ovf_new) m_ovf = 1;
    else if (CLR_OVF) m_ovf = 0;
    if (T_IN != t_last) begin
      arr_q.push_back(k + SS);
      t_last = T_IN;
    end
    e.cnt = m_cnt; e.valid = (m_cnt != 0); e.ack = m_ack; e.ovf = m_ovf;
    exp_q.push_back(e);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Monitor: compare DUT outputs against the queued expectation each cycle.
  always @(negedge C) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("count", int'(EVT_COUNT), e.cnt);
      chk("valid", int'(EVT_VALID), e.valid);
      chk("ack",   int'(ACK_T),     e.ack);
      chk("ovf",   int'(OVF),       e.ovf);
    end
    if (EVT_VALID && EVT_READY) n_hs++;
    if (ACK_T != ack_prev) n_ack++;
    ack_prev = ACK_T;
  end

  task automatic toggle_spaced(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      T_IN = ~T_IN;
      steps(gap);
    end
  endtask

  initial begin
    int lat;
    int maxc;
    int gap;
    ack_prev = 1'b0; n_hs = 0; n_ack = 0;
    model_reset();

    // Reset with T_IN already high: no false event after release
    T_IN = 1'b1;
    #2;
    chk("rst_count", int'(EVT_COUNT), 0);
    chk("rst_valid", int'(EVT_VALID), 0);
    @(posedge C); @(posedge C); #1;
    RST = 1'b0;
    model_reset();
    steps(10);
    chk("warm_valid", int'(EVT_VALID), 0);
    chk("warm_count", int'(EVT_COUNT), 0);

    // Single toggle latency, then one consume
    T_IN = ~T_IN;
    lat = 99;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (EVT_VALID && lat == 99) lat = i;
    end
    chk("latency", lat, 3);
    chk("one_count", int'(EVT_COUNT), 1);
    EVT_READY = 1'b1;
    step();
    EVT_READY = 1'b0;
    chk("consume_count", int'(EVT_COUNT), 0);
    chk("consume_ack", int'(ACK_T), 1);
    steps(2);

    // Sixteen toggles into a 15-deep counter
    toggle_spaced(16, 4);
    steps(4);
    chk("full_count", int'(EVT_COUNT), CMAX);
    chk("full_ovf", int'(OVF), 1);

    // Clear in the same cycle as a fresh overflow: overflow wins
    T_IN = ~T_IN;
    steps(2);
    CLR_OVF = 1'b1;
    step();
    chk("clr_vs_ovf", int'(OVF), 1);
    step();
    CLR_OVF = 1'b0;
    chk("clr_alone", int'(OVF), 0);
    chk("clr_count", int'(EVT_COUNT), CMAX);

    // Drain: exactly 15 consumes and 15 ack toggles
    n_hs = 0; n_ack = 0; ack_prev = ACK_T;
    EVT_READY = 1'b1;
    steps(20);
    EVT_READY = 1'b0;
    step();
    chk("drain_hs", n_hs, CMAX);
    chk("drain_ack", n_ack, CMAX);
    chk("drain_count", int'(EVT_COUNT), 0);

    // Continuous ready with toggles every 4 cycles
    EVT_READY = 1'b1;
    maxc = 0;
    for (int i = 0; i < 12; i++) begin
      T_IN = ~T_IN;
      for (int j = 0; j < 4; j++) begin
        step();
        if (int'(EVT_COUNT) > maxc) maxc = int'(EVT_COUNT);
      end
    end
    chk("ready_max", maxc, 1);
    EVT_READY = 1'b0;
    steps(3);

    // Random traffic: moderate then sparse consumer
    for (int ph = 0; ph < 2; ph++) begin
      gap = 4;
      for (int i = 0; i < 300; i++) begin
        EVT_READY = (ph == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
        CLR_OVF   = ($urandom_range(0, 19) == 0);
        gap--;
        if (gap == 0) begin
          T_IN = ~T_IN;
          gap = $urandom_range(4, 7);
        end
        step();
      end
    end
    EVT_READY = 1'b1; CLR_OVF = 1'b1;
    steps(24);
    EVT_READY = 1'b0; CLR_OVF = 1'b0;
    step();

    // Build up five events, then reset mid-operation
    toggle_spaced(5, 4);
    steps(4);
    chk("pre_rst_count", int'(EVT_COUNT), 5);
    @(negedge C); #1;
    RST = 1'b1;
    #1;
    chk("mid_rst_count", int'(EVT_COUNT), 0);
    chk("mid_rst_valid", int'(EVT_VALID), 0);
    chk("mid_rst_ack", int'(ACK_T), 0);
    chk("mid_rst_ovf", int'(OVF), 0);
    @(posedge C); #1;
    RST = 1'b0;
    model_reset();
    steps(10);
    chk("post_rst_count", int'(EVT_COUNT), 0);
    T_IN = ~T_IN;
    steps(5);
    chk("post_rst_event", int'(EVT_COUNT), 1);

    @(negedge C); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
